// File: rtl/fifo1_sync_if.sv
// Write/read handshake bundle for fifo1_sync; master is the producer/consumer side,
// slave is the FIFO itself.
interface fifo1_sync_if #(
    parameter int DSIZE = 8
) ();
    logic [DSIZE-1:0] WDATA;
    logic             WINC;
    logic             WFULL;
    logic             RINC;
    logic [DSIZE-1:0] RDATA;
    logic             REMPTY;

    modport master (
        output WDATA,
        output WINC,
        output RINC,
        input  WFULL,
        input  RDATA,
        input  REMPTY
    );

    modport slave (
        input  WDATA,
        input  WINC,
        input  RINC,
        output WFULL,
        output RDATA,
        output REMPTY
    );
endinterface

// File: rtl/fifo1_sync.sv
// Single-clock circular FIFO with first-word-fall-through read data and registered
// full/empty flags computed from the next-state pointers.
module fifo1_sync #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 3
) (
    input  logic            CLK,
    input  logic            RST_N,
    fifo1_sync_if.slave     bus
);
    localparam int               DEPTH   = 1 << ASIZE;
    localparam logic [ASIZE:0]   PTR_ONE = 'd1;

    logic [DSIZE-1:0] mem_q [DEPTH];

    logic [ASIZE:0] wptr_q, wptr_d;
    logic [ASIZE:0] rptr_q, rptr_d;
    logic           rempty_q, rempty_d;
    logic           wfull_q, wfull_d;
    logic           wr_en, rd_en;

    always_comb begin
        wr_en    = bus.WINC & ~wfull_q;
        rd_en    = bus.RINC & ~rempty_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        if (wr_en) wptr_d = wptr_q + PTR_ONE;
        if (rd_en) rptr_d = rptr_q + PTR_ONE;
        // Pointers differ only in the wrap bit when the FIFO holds DEPTH words.
        rempty_d = (rptr_d == wptr_d);
        wfull_d  = (wptr_d == {~rptr_d[ASIZE], rptr_d[ASIZE-1:0]});
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            rempty_q <= 1'b1;
            wfull_q  <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            rempty_q <= rempty_d;
            wfull_q  <= wfull_d;
        end
    end

    // Storage is never cleared; gating on RST_N keeps an unknown WINC during reset harmless.
    always_ff @(posedge CLK) begin
        if (RST_N && wr_en) begin
            mem_q[wptr_q[ASIZE-1:0]] <= bus.WDATA;
        end
    end

    assign bus.RDATA  = mem_q[rptr_q[ASIZE-1:0]];
    assign bus.REMPTY = rempty_q;
    assign bus.WFULL  = wfull_q;
endmodule

// File: tb/tb_fifo1_sync.sv
// Directed bench for fifo1_sync: reset, fill/overflow, drain/underflow, wrap,
// simultaneous read/write and mid-operation reset.
module tb_fifo1_sync;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    fifo1_sync_if #(.DSIZE(8)) bus ();

    fifo1_sync #(.DSIZE(8), .ASIZE(3)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] drain_exp [8];
        drain_exp = '{8'd0, 8'd1, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};

        // Reset with unknown requests
        rst_n = 1'b0;
        bus.WINC = 1'bx;
        bus.RINC = 1'bx;
        bus.WDATA = 8'h00;
        tick();
        chk("rst_rempty", bus.REMPTY, 1);
        chk("rst_wfull", bus.WFULL, 0);

        rst_n = 1'b1;
        bus.WINC = 1'b0;
        bus.RINC = 1'b1;
        tick();
        chk("empty_read_rempty", bus.REMPTY, 1);
        chk("empty_read_wfull", bus.WFULL, 0);
        bus.RINC = 1'b0;

        // Fill: 0,1, skip 2, 3..8, then 9..14 dropped
        for (int d = 0; d <= 14; d++) begin
            bus.WDATA = d[7:0];
            bus.WINC  = (d != 2);
            tick();
            if (d == 0) begin
                chk("first_write_rdata", bus.RDATA, 0);
                chk("first_write_rempty", bus.REMPTY, 0);
            end
            if (d == 7) chk("seven_wfull", bus.WFULL, 0);
            if (d == 8) chk("eight_wfull", bus.WFULL, 1);
        end
        bus.WINC = 1'b0;
        chk("full_wfull", bus.WFULL, 1);
        chk("full_rdata_head", bus.RDATA, 0);

        // Drain
        bus.RINC = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_rdata_%0d", i), bus.RDATA, drain_exp[i]);
            tick();
            if (i == 0) chk("drain_wfull_drop", bus.WFULL, 0);
            chk($sformatf("drain_rempty_%0d", i), bus.REMPTY, (i == 7));
        end
        tick();
        tick();
        chk("underflow_rempty", bus.REMPTY, 1);
        chk("underflow_wfull", bus.WFULL, 0);
        bus.RINC = 1'b0;

        // Extra reads must not have moved rptr
        bus.WINC = 1'b1;
        bus.WDATA = 8'hAA;
        tick();
        bus.WINC = 1'b0;
        chk("post_underflow_rdata", bus.RDATA, 8'hAA);
        bus.RINC = 1'b1;
        tick();
        bus.RINC = 1'b0;
        chk("post_underflow_empty", bus.REMPTY, 1);

        // Interleaved bursts of 4, pointers wrap several times
        for (int r = 0; r < 5; r++) begin
            bus.WINC = 1'b1;
            for (int k = 0; k < 4; k++) begin
                bus.WDATA = 8'(16 * r + k);
                tick();
                chk($sformatf("il_w_rempty_%0d_%0d", r, k), bus.REMPTY, 0);
            end
            bus.WINC = 1'b0;
            chk($sformatf("il_wfull_%0d", r), bus.WFULL, 0);
            bus.RINC = 1'b1;
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("il_rdata_%0d_%0d", r, k), bus.RDATA, 16 * r + k);
                tick();
            end
            bus.RINC = 1'b0;
            chk($sformatf("il_rempty_%0d", r), bus.REMPTY, 1);
        end

        // Simultaneous with 3 queued
        bus.WINC = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.WDATA = 8'(8'h50 + k);
            tick();
        end
        bus.WDATA = 8'h53;
        bus.RINC = 1'b1;
        tick();
        bus.WINC = 1'b0;
        bus.RINC = 1'b0;
        chk("sim_mid_rdata", bus.RDATA, 8'h51);
        chk("sim_mid_rempty", bus.REMPTY, 0);
        chk("sim_mid_wfull", bus.WFULL, 0);
        bus.RINC = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("sim_mid_drain_%0d", k), bus.RDATA, 8'h50 + k);
            tick();
        end
        bus.RINC = 1'b0;
        chk("sim_mid_count3_empty", bus.REMPTY, 1);

        // Simultaneous at empty: write wins
        bus.WINC = 1'b1;
        bus.RINC = 1'b1;
        bus.WDATA = 8'h60;
        tick();
        bus.WINC = 1'b0;
        chk("sim_empty_rempty", bus.REMPTY, 0);
        chk("sim_empty_rdata", bus.RDATA, 8'h60);
        tick();
        bus.RINC = 1'b0;
        chk("sim_empty_drained", bus.REMPTY, 1);

        // Simultaneous at full: read wins, write dropped
        bus.WINC = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.WDATA = 8'(8'h70 + k);
            tick();
        end
        chk("sim_full_pre_wfull", bus.WFULL, 1);
        bus.WDATA = 8'hEE;
        bus.RINC = 1'b1;
        tick();
        bus.WINC = 1'b0;
        chk("sim_full_wfull", bus.WFULL, 0);
        chk("sim_full_rdata", bus.RDATA, 8'h71);
        for (int k = 1; k < 8; k++) begin
            chk($sformatf("sim_full_drain_%0d", k), bus.RDATA, 8'h70 + k);
            tick();
        end
        bus.RINC = 1'b0;
        chk("sim_full_dropped_empty", bus.REMPTY, 1);

        // Reset with 5 queued
        bus.WINC = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.WDATA = 8'(8'h80 + k);
            tick();
        end
        bus.WINC = 1'b0;
        chk("pre_reset_rempty", bus.REMPTY, 0);
        rst_n = 1'b0;
        tick();
        chk("midrst_rempty", bus.REMPTY, 1);
        chk("midrst_wfull", bus.WFULL, 0);
        rst_n = 1'b1;
        bus.WINC = 1'b1;
        bus.WDATA = 8'h90;
        tick();
        bus.WDATA = 8'h91;
        tick();
        bus.WINC = 1'b0;
        chk("midrst_rd0", bus.RDATA, 8'h90);
        bus.RINC = 1'b1;
        tick();
        chk("midrst_rd1", bus.RDATA, 8'h91);
        tick();
        bus.RINC = 1'b0;
        chk("midrst_final_empty", bus.REMPTY, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
